// File: rtl/alu_pkg.sv
`default_nettype none
//==============================================================================
// Module   : alu_pkg
// Desc     : Shared types for the pipelined execute block: ALU operation
//            encoding and multiplier sequencer states.
// Macro    : ALU_MUL_EN (consumed by alu_pipe_top, types always present)
// Revision : 1.0 - initial release
//==============================================================================
package alu_pkg;

   localparam int ALU_CTRL_W = 4;

   // Codes 11..15 are reserved: they retire with a zero result and no write.
   typedef enum logic [ALU_CTRL_W-1:0] {
      ALU_ADD  = 4'd0,
      ALU_SUB  = 4'd1,
      ALU_AND  = 4'd2,
      ALU_OR   = 4'd3,
      ALU_XOR  = 4'd4,
      ALU_SLT  = 4'd5,
      ALU_SLTU = 4'd6,
      ALU_SLL  = 4'd7,
      ALU_SRL  = 4'd8,
      ALU_SRA  = 4'd9,
      ALU_MUL  = 4'd10
   } alu_op_e;

   typedef enum logic [1:0] {
      MUL_IDLE = 2'd0,
      MUL_BUSY = 2'd1,
      MUL_DONE = 2'd2
   } mul_state_e;

endpackage
`default_nettype wire

// File: rtl/alu_pipe_if.sv
`default_nettype none
//==============================================================================
// Module   : alu_pipe_if
// Desc     : Decode-side instruction handshake plus retire/a0 observation
//            signals of the pipelined execute block.
// Macro    : none
// Revision : 1.0 - initial release
//==============================================================================
interface alu_pipe_if #(
   parameter int DATA_WIDTH    = 32,
   parameter int ADDRESS_WIDTH = 5
) ();

   logic                          in_valid;
   logic                          in_ready;
   logic [alu_pkg::ALU_CTRL_W-1:0] alu_ctrl;
   logic                          alu_src;
   logic [ADDRESS_WIDTH-1:0]      rs1;
   logic [ADDRESS_WIDTH-1:0]      rs2;
   logic [ADDRESS_WIDTH-1:0]      rd;
   logic                          reg_write;
   logic [DATA_WIDTH-1:0]         imm_op;
   logic                          out_valid;
   logic [DATA_WIDTH-1:0]         out_result;
   logic                          out_eq;
   logic [DATA_WIDTH-1:0]         a0;

   // Decode side: issues instructions, observes results.
   modport master (
      output in_valid, alu_ctrl, alu_src, rs1, rs2, rd, reg_write, imm_op,
      input  in_ready, out_valid, out_result, out_eq, a0
   );

   // Execute block side.
   modport slave (
      input  in_valid, alu_ctrl, alu_src, rs1, rs2, rd, reg_write, imm_op,
      output in_ready, out_valid, out_result, out_eq, a0
   );

endinterface
`default_nettype wire

// File: rtl/alu_mul_seq.sv
`default_nettype none
//==============================================================================
// Module   : alu_mul_seq
// Desc     : Radix-2 shift-add multiplier, one partial product per cycle.
//            Operands are captured on i_start; o_done is high for one cycle
//            after DATA_WIDTH iterations with the low product bits valid.
// Macro    : instantiated only when ALU_MUL_EN is defined
// Revision : 1.0 - initial release
//==============================================================================
module alu_mul_seq
   import alu_pkg::*;
#(
   parameter int DATA_WIDTH = 32
) (
   input  wire                   clk,
   input  wire                   rst_n,
   input  wire                   i_start,
   input  wire  [DATA_WIDTH-1:0] i_op1,
   input  wire  [DATA_WIDTH-1:0] i_op2,
   output logic                  o_busy,
   output logic                  o_done,
   output logic [DATA_WIDTH-1:0] o_product
);

   localparam int                c_cntw = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
   localparam logic [c_cntw-1:0] c_last = c_cntw'(DATA_WIDTH - 1);

   mul_state_e            r_state;
   mul_state_e            w_next;
   logic [c_cntw-1:0]     r_cnt;
   logic [DATA_WIDTH-1:0] r_mcand;
   logic [DATA_WIDTH-1:0] r_mplier;
   logic [DATA_WIDTH-1:0] r_acc;

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= MUL_IDLE;
      else        r_state <= w_next;
   end

   // Next state: a start may also arrive in DONE, since the pipe accepts then.
   always_comb begin
      w_next = r_state;
      case (r_state)
         MUL_IDLE: if (i_start) w_next = MUL_BUSY;
         MUL_BUSY: if (r_cnt == c_last) w_next = MUL_DONE;
         MUL_DONE: w_next = i_start ? MUL_BUSY : MUL_IDLE;
         default:  w_next = MUL_IDLE;
      endcase
   end

   // Shift-add datapath: add multiplicand when multiplier LSB is set.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt    <= '0;
         r_mcand  <= '0;
         r_mplier <= '0;
         r_acc    <= '0;
      end else if (i_start) begin
         r_cnt    <= '0;
         r_mcand  <= i_op1;
         r_mplier <= i_op2;
         r_acc    <= '0;
      end else if (r_state == MUL_BUSY) begin
         if (r_mplier[0]) r_acc <= r_acc + r_mcand;
         r_mcand  <= r_mcand << 1;
         r_mplier <= r_mplier >> 1;
         r_cnt    <= r_cnt + 1'b1;
      end
   end

   assign o_busy    = (r_state == MUL_BUSY);
   assign o_done    = (r_state == MUL_DONE);
   assign o_product = r_acc;

endmodule
`default_nettype wire

// File: rtl/alu_pipe_top.sv
`default_nettype none
//==============================================================================
// Module   : alu_pipe_top
// Desc     : Two-stage execute block. Stage 1 reads the register file (with
//            forwarding from stage 2) and selects operands; stage 2 runs the
//            ALU, writes back and registers the retire outputs.
// Macro    : ALU_MUL_EN - adds the sequential multiplier for op 10 and the
//            stall it needs; otherwise op 10 is reserved and in_ready is 1.
// Revision : 1.0 - initial release
//==============================================================================
module alu_pipe_top
   import alu_pkg::*;
#(
   parameter int DATA_WIDTH    = 32,
   parameter int ADDRESS_WIDTH = 5,
   parameter int A0_INDEX      = 10
) (
   input wire        clk,
   input wire        rst_n,
   alu_pipe_if.slave bus
);

   localparam int c_nregs = 2 ** ADDRESS_WIDTH;
   localparam int c_shw   = $clog2(DATA_WIDTH);

   logic [DATA_WIDTH-1:0]    r_regs [c_nregs];

   logic                     r_s2_valid;
   logic                     r_s2_we;
   logic [ALU_CTRL_W-1:0]    r_s2_op;
   logic [DATA_WIDTH-1:0]    r_s2_op1;
   logic [DATA_WIDTH-1:0]    r_s2_op2;
   logic [ADDRESS_WIDTH-1:0] r_s2_rd;

   logic                     r_out_valid;
   logic [DATA_WIDTH-1:0]    r_out_result;
   logic                     r_out_eq;

   logic                     w_in_ready;
   logic                     w_accept;
   logic                     w_retire;
   logic                     w_op_legal;
   logic                     w_wr_en;
   logic                     w_fwd1;
   logic                     w_fwd2;
   logic [DATA_WIDTH-1:0]    w_rd1;
   logic [DATA_WIDTH-1:0]    w_rd2;
   logic [DATA_WIDTH-1:0]    w_op1;
   logic [DATA_WIDTH-1:0]    w_op2;
   logic [DATA_WIDTH-1:0]    w_alu_result;
   logic [DATA_WIDTH-1:0]    w_s2_result;
   logic [c_shw-1:0]         w_shamt;

   assign w_accept = bus.in_valid && w_in_ready;

`ifdef ALU_MUL_EN
   logic                  w_s2_is_mul;
   logic                  w_mul_start;
   logic                  w_mul_busy;
   logic                  w_mul_done;
   logic [DATA_WIDTH-1:0] w_mul_product;

   // The multiplier starts as the MUL enters stage 2, so the stall covers
   // exactly the iteration cycles and the product retires in DONE.
   assign w_s2_is_mul = (r_s2_op == ALU_MUL);
   assign w_mul_start = w_accept && (bus.alu_ctrl == ALU_MUL);

   alu_mul_seq #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_mul (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_start   (w_mul_start),
      .i_op1     (w_op1),
      .i_op2     (w_op2),
      .o_busy    (w_mul_busy),
      .o_done    (w_mul_done),
      .o_product (w_mul_product)
   );

   assign w_in_ready  = ~w_mul_busy;
   assign w_retire    = r_s2_valid && (!w_s2_is_mul || w_mul_done);
   assign w_s2_result = w_s2_is_mul ? w_mul_product : w_alu_result;
   assign w_op_legal  = (r_s2_op <= ALU_MUL);
`else
   assign w_in_ready  = 1'b1;
   assign w_retire    = r_s2_valid;
   assign w_s2_result = w_alu_result;
   assign w_op_legal  = (r_s2_op <= ALU_SRA);
`endif

   // x0 and reserved ops never write, and therefore never forward either.
   assign w_wr_en = w_retire && r_s2_we && w_op_legal && (r_s2_rd != '0);
   assign w_fwd1  = w_wr_en && (r_s2_rd == bus.rs1);
   assign w_fwd2  = w_wr_en && (r_s2_rd == bus.rs2);

   assign w_rd1 = (bus.rs1 == '0) ? '0 : r_regs[bus.rs1];
   assign w_rd2 = (bus.rs2 == '0) ? '0 : r_regs[bus.rs2];
   assign w_op1 = w_fwd1 ? w_s2_result : w_rd1;
   assign w_op2 = bus.alu_src ? bus.imm_op : (w_fwd2 ? w_s2_result : w_rd2);

   // Stage-2 capture; held while the multiplier stalls the pipe.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s2_valid <= 1'b0;
         r_s2_we    <= 1'b0;
         r_s2_op    <= '0;
         r_s2_op1   <= '0;
         r_s2_op2   <= '0;
         r_s2_rd    <= '0;
      end else if (w_in_ready) begin
         r_s2_valid <= bus.in_valid;
         if (bus.in_valid) begin
            r_s2_we  <= bus.reg_write;
            r_s2_op  <= bus.alu_ctrl;
            r_s2_op1 <= w_op1;
            r_s2_op2 <= w_op2;
            r_s2_rd  <= bus.rd;
         end
      end
   end

   assign w_shamt = r_s2_op2[c_shw-1:0];

   // Single-cycle ALU; MUL and reserved codes fall to zero here.
   always_comb begin
      w_alu_result = '0;
      case (r_s2_op)
         ALU_ADD:  w_alu_result = r_s2_op1 + r_s2_op2;
         ALU_SUB:  w_alu_result = r_s2_op1 - r_s2_op2;
         ALU_AND:  w_alu_result = r_s2_op1 & r_s2_op2;
         ALU_OR:   w_alu_result = r_s2_op1 | r_s2_op2;
         ALU_XOR:  w_alu_result = r_s2_op1 ^ r_s2_op2;
         ALU_SLT:  w_alu_result = {{(DATA_WIDTH-1){1'b0}},
                                   ($signed(r_s2_op1) < $signed(r_s2_op2))};
         ALU_SLTU: w_alu_result = {{(DATA_WIDTH-1){1'b0}}, (r_s2_op1 < r_s2_op2)};
         ALU_SLL:  w_alu_result = r_s2_op1 << w_shamt;
         ALU_SRL:  w_alu_result = r_s2_op1 >> w_shamt;
         ALU_SRA:  w_alu_result = $unsigned($signed(r_s2_op1) >>> w_shamt);
         default:  w_alu_result = '0;
      endcase
   end

   // Register file write port; entry 0 is never written.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < c_nregs; i++) r_regs[i] <= '0;
      end else if (w_wr_en) begin
         r_regs[r_s2_rd] <= w_s2_result;
      end
   end

   // Retire outputs: one-cycle valid pulse, result and eq held until next retire.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_out_valid  <= 1'b0;
         r_out_result <= '0;
         r_out_eq     <= 1'b0;
      end else begin
         r_out_valid <= w_retire;
         if (w_retire) begin
            r_out_result <= w_s2_result;
            r_out_eq     <= (r_s2_op1 == r_s2_op2);
         end
      end
   end

   assign bus.in_ready   = w_in_ready;
   assign bus.out_valid  = r_out_valid;
   assign bus.out_result = r_out_result;
   assign bus.out_eq     = r_out_eq;
   assign bus.a0         = r_regs[A0_INDEX];

endmodule
`default_nettype wire
